axi_to_uart_s00: RTL and testbench
==================================

AXI_TO_UART_S00 -- requirements
Module: axi_to_uart_s00

Interface
REQ-001 Parameters SHALL be: C_S_AXI_DATA_WIDTH, default 32, AXI data width (only 32 supported); C_S_AXI_ADDR_WIDTH, default 6, AXI byte-address width; CLKS_PER_BIT, default 868, clocks per UART bit (115200 baud at 100 MHz).
REQ-002 The block SHALL use one clock and a synchronous, active-high reset, on the ports below.
REQ-003 Ports SHALL be, as name, direction, width, meaning:
- S_AXI_ACLK in 1: sole clock.
- S_AXI_ARESETN in 1: synchronous active-high reset, level 1 = reset.
- S_AXI_AWADDR/AWPROT/AWVALID in 6/3/1, S_AXI_AWREADY out 1: write address channel; AWPROT ignored.
- S_AXI_WDATA/WSTRB/WVALID in 32/4/1, S_AXI_WREADY out 1: write data channel.
- S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1: write response channel.
- S_AXI_ARADDR/ARPROT/ARVALID in 6/3/1, S_AXI_ARREADY out 1: read address channel; ARPROT ignored.
- S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1: read data channel.
- uart_rxd in 1: serial receive line, idle high.
- uart_txd out 1: serial transmit line, idle high.
- uart_clk_edge out 1: one-cycle pulse at every TX bit boundary.
- o_SM_Main out 3: TX state encoding.
- dbg_uart_write_en out 1: one-cycle pulse when a TX byte is accepted.
- dbg_uart_writing out 1: high from byte acceptance until its stop bit completes.
- dbg_uart_write_data out 8: last accepted TX byte.
- dbg_uart_write_finished out 1: one-cycle pulse when a byte has been fully sent.
- dbg_uart_write_count out 8: bytes sent, wraps 255 to 0.
- dbg_o_tx_active, dbg_o_tx_serial, dbg_o_tx_done out 1 each: raw TX core active, serial and done signals.

Function
REQ-004 Register map (word index = addr[5:2], addr[1:0] ignored): 0x00 TX_DATA (W; RDATA = last TX byte), 0x04 STATUS (R: bit0 tx_busy, bit1 tx_done sticky, bit2 rx_valid, bit3 rx_overrun), 0x08 RX_DATA (R, bits[7:0]), 0x0C TX_COUNT (R, bits[7:0]), 0x10 SCRATCH (RW, byte strobes honoured); all other offsets read 0, writes ignored; RRESP and BRESP always 2'b00.
REQ-005 Write handshake: when AWVALID&WVALID&!AWREADY&!BVALID, assert AWREADY and WREADY together for exactly one cycle; the register write happens in that cycle; BVALID rises the next cycle and holds until BREADY.
REQ-006 Read handshake: when ARVALID&!ARREADY&!RVALID, pulse ARREADY for one cycle; RVALID rises the next cycle with RDATA latched and holds, data stable, until RREADY.
REQ-007 A TX_DATA write with WSTRB[0]=1 while the transmitter is idle SHALL load WDATA[7:0], pulse dbg_uart_write_en, set tx_busy and clear tx_done; if the transmitter is busy, the write is dropped (still OKAY) and the counter is unchanged.
REQ-008 TX state machine o_SM_Main: 0 IDLE, 1 START, 2 DATA, 3 STOP, 4 CLEANUP; each of START, each DATA bit (LSB first) and STOP lasts CLKS_PER_BIT cycles; CLEANUP lasts 1 cycle, pulses dbg_o_tx_done and dbg_uart_write_finished, increments the count, sets tx_done, then returns to IDLE.
REQ-009 uart_txd SHALL be 1 in IDLE, 0 in START, the data bit in DATA, 1 in STOP and CLEANUP.
REQ-010 RX SHALL detect the falling edge, confirm the start bit at mid-bit, sample 8 bits at mid-bit (LSB first), require a high stop bit, load RX_DATA and set rx_valid; a frame with a bad stop bit is discarded.
REQ-011 A new byte arriving while rx_valid=1 SHALL set rx_overrun and overwrite RX_DATA; reading RX_DATA clears rx_valid; reading STATUS clears tx_done and rx_overrun after the read completes.
REQ-012 Simultaneous AXI read and write SHALL be served independently in the same cycle.

Reset
REQ-013 While reset is high: all READY/VALID outputs 0, RDATA 0, uart_txd 1, o_SM_Main 0, all registers, counters and debug outputs 0; reset mid-frame aborts the frame immediately with txd returning high.

Structure
REQ-014 Package axi_to_uart_pkg SHALL hold the register offsets, the TX state enum and the STATUS bit indices.
REQ-015 A sub-module uart_tx_core (IDLE..CLEANUP FSM, CLKS_PER_BIT counter) SHALL be instantiated; the AXI decode and RX logic are in the top.

Verification
REQ-016 Hold reset for 2 cycles, release -> all handshake outputs 0, uart_txd=1, o_SM_Main=0.
REQ-017 Write 0x00=0x000000A5, WSTRB=0xF -> one-cycle AWREADY/WREADY, BVALID, BRESP=0; txd frame 0,1,0,1,0,0,1,0,1,1 at CLKS_PER_BIT spacing; count=1.
REQ-018 Second TX_DATA write during an active frame -> dropped, count stays 1, dbg_uart_write_data stays 0xA5.
REQ-019 Drive frame 0x3C on uart_rxd -> STATUS bit2=1, RX_DATA=0x3C; second frame before the read -> bit3=1.
REQ-020 Write SCRATCH=0x12345678 with WSTRB=0x3, then read -> 0x00005678; read 0x3C -> 0; RVALID held with RREADY=0 for 3 cycles.
REQ-021 Assert reset mid-DATA -> txd=1 and o_SM_Main=0 on the next edge.

Source files
------------

// File: rtl/axi_to_uart_pkg.sv
// Shared definitions for the AXI-Lite UART bridge: register word offsets,
// STATUS bit positions, TX/RX state encodings and a byte-strobe merge helper.
package axi_to_uart_pkg;

  // Register word indices (byte address bits [5:2])
  localparam logic [3:0] REG_TX_DATA  = 4'h0;
  localparam logic [3:0] REG_STATUS   = 4'h1;
  localparam logic [3:0] REG_RX_DATA  = 4'h2;
  localparam logic [3:0] REG_TX_COUNT = 4'h3;
  localparam logic [3:0] REG_SCRATCH  = 4'h4;

  // STATUS register bit positions
  localparam int STAT_TX_BUSY    = 0;
  localparam int STAT_TX_DONE    = 1;
  localparam int STAT_RX_VALID   = 2;
  localparam int STAT_RX_OVERRUN = 3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Encoding is visible on o_SM_Main, so the values are fixed
  typedef enum logic [2:0] {
    TX_IDLE    = 3'd0,
    TX_START   = 3'd1,
    TX_DATA    = 3'd2,
    TX_STOP    = 3'd3,
    TX_CLEANUP = 3'd4
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Merge new write data into an existing word, one byte lane per strobe bit
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] result;
    result = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) result[8*i +: 8] = new_word[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/axi_to_uart_tx_core.sv
// UART transmitter core: 8N1 framing, LSB first, CLKS_PER_BIT clocks per bit.
// All outputs are registered; o_tx_done is high exactly during CLEANUP.
module uart_tx_core
  import axi_to_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tx_dv,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_active,
  output logic       o_tx_serial,
  output logic       o_tx_done,
  output logic       o_bit_edge,
  output logic [2:0] o_sm_main
);

  localparam int              CW       = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]   BIT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_e       r_state;
  logic [CW-1:0]   r_clk_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_byte;
  logic            r_active;
  logic            r_serial;
  logic            r_done;
  logic            r_edge;
  logic            w_bit_end;

  assign w_bit_end = (r_clk_cnt == BIT_LAST);

  // Frame sequencer: state, bit timer and every registered output
  // NOTE: state is updated with <= so all registers sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= TX_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_byte    <= '0;
      r_active  <= 1'b0;
      r_serial  <= 1'b1;
      r_done    <= 1'b0;
      r_edge    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_edge <= 1'b0;
      case (r_state)
        TX_IDLE: begin
          r_serial  <= 1'b1;
          r_clk_cnt <= '0;
          r_bit_idx <= '0;
          if (i_tx_dv) begin
            r_byte   <= i_tx_byte;
            r_active <= 1'b1;
            r_serial <= 1'b0;
            r_state  <= TX_START;
          end
        end
        TX_START: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_edge    <= 1'b1;
            r_serial  <= r_byte[0];
            r_state   <= TX_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_edge    <= 1'b1;
            if (r_bit_idx == 3'd7) begin
              r_bit_idx <= '0;
              r_serial  <= 1'b1;
              r_state   <= TX_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_serial  <= r_byte[r_bit_idx + 3'd1];
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_edge    <= 1'b1;
            r_active  <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= TX_CLEANUP;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        TX_CLEANUP: begin
          r_state <= TX_IDLE;
        end
        default: begin
          r_state  <= TX_IDLE;
          r_serial <= 1'b1;
        end
      endcase
    end
  end

  assign o_tx_active = r_active;
  assign o_tx_serial = r_serial;
  assign o_tx_done   = r_done;
  assign o_bit_edge  = r_edge;
  assign o_sm_main   = r_state;

endmodule

// File: rtl/axi_to_uart_s00.sv
// AXI4-Lite slave exposing a UART: TX data/status/RX data/count/scratch
// registers, an 8N1 receiver and an instantiated transmitter core.
module axi_to_uart_s00
  import axi_to_uart_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int CLKS_PER_BIT       = 868
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            uart_rxd,
  output logic                            uart_txd,
  output logic                            uart_clk_edge,
  output logic [2:0]                      o_SM_Main,
  output logic                            dbg_uart_write_en,
  output logic                            dbg_uart_writing,
  output logic [7:0]                      dbg_uart_write_data,
  output logic                            dbg_uart_write_finished,
  output logic [7:0]                      dbg_uart_write_count,
  output logic                            dbg_o_tx_active,
  output logic                            dbg_o_tx_serial,
  output logic                            dbg_o_tx_done
);

  localparam int            CW       = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'((CLKS_PER_BIT - 1) / 2);

  // The reset port keeps its AXI name but is active high
  logic w_rst;
  assign w_rst = S_AXI_ARESETN;

  // AXI channel registers
  logic        r_awready, r_wready, r_bvalid;
  logic        r_arready, r_rvalid;
  logic [31:0] r_rdata;
  logic        r_rd_clr_done, r_rd_clr_ovr, r_rd_clr_rx;

  // Register file
  logic [7:0]  r_last_tx;
  logic        r_write_en;
  logic        r_tx_done;
  logic [7:0]  r_tx_count;
  logic [31:0] r_scratch;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid, r_rx_overrun;

  // Receiver
  rx_state_e     r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_idx;
  logic [7:0]    r_rx_shift;
  logic          r_rxd_meta, r_rxd_sync, r_rxd_prev;

  // Transmitter core hookup
  logic       w_core_active, w_core_serial, w_core_done, w_core_edge;
  logic [2:0] w_sm_main;

  logic        w_wr_fire, w_rd_hs, w_tx_idle, w_tx_accept, w_rx_frame_ok;
  logic [3:0]  w_wr_idx, w_rd_idx;
  logic [31:0] w_rd_mux;
  logic        w_unused;

  assign w_wr_fire     = r_awready;
  assign w_rd_hs       = r_rvalid & S_AXI_RREADY;
  assign w_wr_idx      = S_AXI_AWADDR[5:2];
  assign w_rd_idx      = S_AXI_ARADDR[5:2];
  assign w_tx_idle     = (w_sm_main == TX_IDLE);
  assign w_tx_accept   = w_wr_fire && (w_wr_idx == REG_TX_DATA) && S_AXI_WSTRB[0] && w_tx_idle;
  assign w_rx_frame_ok = (r_rx_state == RX_STOP) && (r_rx_cnt == BIT_LAST) && r_rxd_sync;
  assign w_unused      = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  uart_tx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx_core (
    .clk         (S_AXI_ACLK),
    .rst         (w_rst),
    .i_tx_dv     (w_tx_accept),
    .i_tx_byte   (S_AXI_WDATA[7:0]),
    .o_tx_active (w_core_active),
    .o_tx_serial (w_core_serial),
    .o_tx_done   (w_core_done),
    .o_bit_edge  (w_core_edge),
    .o_sm_main   (w_sm_main)
  );

  // Write channel: one-cycle AWREADY/WREADY pulse, then BVALID until BREADY
  always_ff @(posedge S_AXI_ACLK) begin
    if (w_rst) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      if (S_AXI_AWVALID && S_AXI_WVALID && !r_awready && !r_bvalid) begin
        r_awready <= 1'b1;
        r_wready  <= 1'b1;
      end
      if (w_wr_fire)                   r_bvalid <= 1'b1;
      else if (r_bvalid && S_AXI_BREADY) r_bvalid <= 1'b0;
    end
  end

  // Read data selection for the address presented during the ARREADY cycle
  // NOTE: default first so every path assigns w_rd_mux and no latch is inferred.
  always_comb begin
    w_rd_mux = '0;
    case (w_rd_idx)
      REG_TX_DATA:  w_rd_mux = {24'd0, r_last_tx};
      REG_STATUS:   w_rd_mux = {28'd0, r_rx_overrun, r_rx_valid, r_tx_done, !w_tx_idle};
      REG_RX_DATA:  w_rd_mux = {24'd0, r_rx_data};
      REG_TX_COUNT: w_rd_mux = {24'd0, r_tx_count};
      REG_SCRATCH:  w_rd_mux = r_scratch;
      default:      w_rd_mux = '0;
    endcase
  end

  // Read channel: ARREADY pulse, then RVALID with latched data until RREADY;
  // remembers which clear-on-read side effects the returned word implies
  always_ff @(posedge S_AXI_ACLK) begin
    if (w_rst) begin
      r_arready     <= 1'b0;
      r_rvalid      <= 1'b0;
      r_rdata       <= '0;
      r_rd_clr_done <= 1'b0;
      r_rd_clr_ovr  <= 1'b0;
      r_rd_clr_rx   <= 1'b0;
    end else begin
      r_arready <= 1'b0;
      if (S_AXI_ARVALID && !r_arready && !r_rvalid) r_arready <= 1'b1;
      if (r_arready) begin
        r_rvalid      <= 1'b1;
        r_rdata       <= w_rd_mux;
        r_rd_clr_done <= (w_rd_idx == REG_STATUS) && r_tx_done;
        r_rd_clr_ovr  <= (w_rd_idx == REG_STATUS) && r_rx_overrun;
        r_rd_clr_rx   <= (w_rd_idx == REG_RX_DATA);
      end else if (w_rd_hs) begin
        r_rvalid      <= 1'b0;
        r_rd_clr_done <= 1'b0;
        r_rd_clr_ovr  <= 1'b0;
        r_rd_clr_rx   <= 1'b0;
      end
    end
  end

  // Register file: scratch, TX bookkeeping, RX data/flags
  always_ff @(posedge S_AXI_ACLK) begin
    if (w_rst) begin
      r_scratch    <= '0;
      r_last_tx    <= '0;
      r_write_en   <= 1'b0;
      r_tx_done    <= 1'b0;
      r_tx_count   <= '0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      r_write_en <= w_tx_accept;
      if (w_wr_fire && (w_wr_idx == REG_SCRATCH))
        r_scratch <= apply_wstrb(r_scratch, S_AXI_WDATA, S_AXI_WSTRB);
      if (w_tx_accept) r_last_tx <= S_AXI_WDATA[7:0];
      if (w_core_done) r_tx_count <= r_tx_count + 8'd1;
      // A completion event always wins over a concurrent clear
      if (w_core_done)                            r_tx_done <= 1'b1;
      else if (w_tx_accept || (w_rd_hs && r_rd_clr_done)) r_tx_done <= 1'b0;
      if (w_rx_frame_ok) begin
        r_rx_data  <= r_rx_shift;
        r_rx_valid <= 1'b1;
      end else if (w_rd_hs && r_rd_clr_rx) begin
        r_rx_valid <= 1'b0;
      end
      if (w_rx_frame_ok && r_rx_valid)      r_rx_overrun <= 1'b1;
      else if (w_rd_hs && r_rd_clr_ovr)     r_rx_overrun <= 1'b0;
    end
  end

  // RX line synchroniser plus previous-sample copy for falling-edge detection
  always_ff @(posedge S_AXI_ACLK) begin
    if (w_rst) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
      r_rxd_prev <= 1'b1;
    end else begin
      r_rxd_meta <= uart_rxd;
      r_rxd_sync <= r_rxd_meta;
      r_rxd_prev <= r_rxd_sync;
    end
  end

  // RX framer: confirm start at mid-bit, then sample each bit at its centre
  always_ff @(posedge S_AXI_ACLK) begin
    if (w_rst) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
    end else begin
      case (r_rx_state)
        RX_IDLE: begin
          r_rx_cnt <= '0;
          r_rx_idx <= '0;
          if (r_rxd_prev && !r_rxd_sync) r_rx_state <= RX_START;
        end
        RX_START: begin
          if (r_rx_cnt == BIT_HALF) begin
            r_rx_cnt   <= '0;
            r_rx_state <= r_rxd_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == BIT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rxd_sync, r_rx_shift[7:1]};
            r_rx_idx   <= r_rx_idx + 3'd1;
            if (r_rx_idx == 3'd7) r_rx_state <= RX_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          // A low stop bit drops the frame; the line is then still low, so
          // no false start edge is seen until it returns high
          if (r_rx_cnt == BIT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY           = r_awready;
  assign S_AXI_WREADY            = r_wready;
  assign S_AXI_BRESP             = RESP_OKAY;
  assign S_AXI_BVALID            = r_bvalid;
  assign S_AXI_ARREADY           = r_arready;
  assign S_AXI_RDATA             = r_rdata;
  assign S_AXI_RRESP             = RESP_OKAY;
  assign S_AXI_RVALID            = r_rvalid;
  assign uart_txd                = w_core_serial;
  assign uart_clk_edge           = w_core_edge;
  assign o_SM_Main               = w_sm_main;
  assign dbg_uart_write_en       = r_write_en;
  assign dbg_uart_writing        = w_core_active;
  assign dbg_uart_write_data     = r_last_tx;
  assign dbg_uart_write_finished = w_core_done;
  assign dbg_uart_write_count    = r_tx_count;
  assign dbg_o_tx_active         = w_core_active;
  assign dbg_o_tx_serial         = w_core_serial;
  assign dbg_o_tx_done           = w_core_done;

endmodule

// File: tb/tb_axi_to_uart_s00.sv
// Directed testbench for axi_to_uart_s00 with a short bit period.
module tb_axi_to_uart_s00;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic        uart_rxd, uart_txd, uart_clk_edge;
  logic [2:0]  sm_main;
  logic        d_wen, d_writing, d_finished, d_active, d_serial, d_done;
  logic [7:0]  d_wdata, d_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_to_uart_s00 #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (6),
    .CLKS_PER_BIT       (CPB)
  ) dut (
    .S_AXI_ACLK              (clk),
    .S_AXI_ARESETN           (rst),
    .S_AXI_AWADDR            (awaddr),
    .S_AXI_AWPROT            (awprot),
    .S_AXI_AWVALID           (awvalid),
    .S_AXI_AWREADY           (awready),
    .S_AXI_WDATA             (wdata),
    .S_AXI_WSTRB             (wstrb),
    .S_AXI_WVALID            (wvalid),
    .S_AXI_WREADY            (wready),
    .S_AXI_BRESP             (bresp),
    .S_AXI_BVALID            (bvalid),
    .S_AXI_BREADY            (bready),
    .S_AXI_ARADDR            (araddr),
    .S_AXI_ARPROT            (arprot),
    .S_AXI_ARVALID           (arvalid),
    .S_AXI_ARREADY           (arready),
    .S_AXI_RDATA             (rdata),
    .S_AXI_RRESP             (rresp),
    .S_AXI_RVALID            (rvalid),
    .S_AXI_RREADY            (rready),
    .uart_rxd                (uart_rxd),
    .uart_txd                (uart_txd),
    .uart_clk_edge           (uart_clk_edge),
    .o_SM_Main               (sm_main),
    .dbg_uart_write_en       (d_wen),
    .dbg_uart_writing        (d_writing),
    .dbg_uart_write_data     (d_wdata),
    .dbg_uart_write_finished (d_finished),
    .dbg_uart_write_count    (d_count),
    .dbg_o_tx_active         (d_active),
    .dbg_o_tx_serial         (d_serial),
    .dbg_o_tx_done           (d_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int t;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!awready && t < 16);
    check("aw_w_ready", {30'd0, awready, wready}, 32'h3);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("awready_one_cycle", {31'd0, awready}, 32'h0);
    check("bvalid_set", {31'd0, bvalid}, 32'h1);
    check("bresp", {30'd0, bresp}, 32'h0);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("bvalid_clear", {31'd0, bvalid}, 32'h0);
  endtask

  task automatic axi_read(input string tag, input logic [5:0] addr, input logic [31:0] exp, input int hold);
    int t;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; rready = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!arready && t < 16);
    check("arready", {31'd0, arready}, 32'h1);
    @(negedge clk);
    arvalid = 1'b0;
    check("rvalid_set", {31'd0, rvalid}, 32'h1);
    check("rresp", {30'd0, rresp}, 32'h0);
    check(tag, rdata, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rvalid_hold", {31'd0, rvalid}, 32'h1);
      check("rdata_stable", rdata, exp);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("rvalid_clear", {31'd0, rvalid}, 32'h0);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      uart_rxd = f[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk);
    uart_rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] frame;
    logic [2:0] exp_sm;

    rst = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    uart_rxd = 1'b1;

    // Reset held for two cycles, then released
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_txd", {31'd0, uart_txd}, 32'h1);
    check("rst_rdata", rdata, 32'h0);
    check("rst_count", {24'd0, d_count}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_handshakes", {27'd0, awready, wready, bvalid, arready, rvalid}, 32'h0);
    check("rel_txd", {31'd0, uart_txd}, 32'h1);
    check("rel_sm", {29'd0, sm_main}, 32'h0);

    // Transmit 0xA5; a second write during the frame must be dropped
    axi_write(6'h00, 32'h0000_00A5, 4'hF);
    check("tx_wdata", {24'd0, d_wdata}, 32'hA5);
    check("tx_writing", {31'd0, d_writing}, 32'h1);
    axi_write(6'h00, 32'h0000_0077, 4'hF);
    check("drop_wdata", {24'd0, d_wdata}, 32'hA5);
    repeat (2) @(negedge clk);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) begin
      exp_sm = (k == 0) ? 3'd1 : ((k == 9) ? 3'd3 : 3'd2);
      check("tx_bit", {31'd0, uart_txd}, {31'd0, frame[k]});
      check("tx_sm", {29'd0, sm_main}, {29'd0, exp_sm});
      repeat (CPB) @(negedge clk);
    end
    check("tx_count_1", {24'd0, d_count}, 32'h1);
    check("tx_sm_idle", {29'd0, sm_main}, 32'h0);
    check("tx_txd_idle", {31'd0, uart_txd}, 32'h1);
    repeat (CPB) @(negedge clk);
    check("drop_no_resend", {29'd0, sm_main}, 32'h0);
    check("drop_count", {24'd0, d_count}, 32'h1);

    // Status: tx_done sticky, cleared by reading STATUS
    axi_read("status_done", 6'h04, 32'h2, 0);
    axi_read("status_cleared", 6'h04, 32'h0, 0);
    axi_read("tx_count_reg", 6'h0C, 32'h1, 0);
    axi_read("tx_data_reg", 6'h00, 32'hA5, 0);

    // Receive path, overrun, and a frame with a bad stop bit
    send_rx(8'h3C, 1'b1);
    axi_read("rx_status_valid", 6'h04, 32'h4, 0);
    send_rx(8'hC3, 1'b1);
    axi_read("rx_status_overrun", 6'h04, 32'hC, 0);
    axi_read("rx_data_second", 6'h08, 32'hC3, 0);
    axi_read("rx_status_clear", 6'h04, 32'h0, 0);
    send_rx(8'h55, 1'b0);
    axi_read("rx_bad_stop", 6'h04, 32'h0, 0);
    send_rx(8'h3C, 1'b1);
    axi_read("rx_data_3c", 6'h0B, 32'h3C, 0);

    // Scratch with partial strobes, unmapped read, RVALID hold under back-pressure
    axi_write(6'h10, 32'h1234_5678, 4'h3);
    axi_read("scratch", 6'h10, 32'h0000_5678, 3);
    axi_write(6'h3C, 32'hDEAD_BEEF, 4'hF);
    axi_read("unmapped", 6'h3C, 32'h0, 0);

    // Reset during the DATA phase of a frame of zeros
    axi_write(6'h00, 32'h0000_0000, 4'hF);
    repeat (24) @(negedge clk);
    check("mid_sm_data", {29'd0, sm_main}, 32'h2);
    check("mid_txd_low", {31'd0, uart_txd}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_txd", {31'd0, uart_txd}, 32'h1);
    check("abort_sm", {29'd0, sm_main}, 32'h0);
    check("abort_count", {24'd0, d_count}, 32'h0);
    check("abort_wdata", {24'd0, d_wdata}, 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_abort_txd", {31'd0, uart_txd}, 32'h1);
    axi_read("post_abort_scratch", 6'h10, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
